stream_pack: RTL and testbench
==============================

// Module: stream_pack
// PURPOSE
//  Downstream neighbour of the bubble-free pipeline stage. Consumes its valid/ready
//  stream (data_b/vld_b/rdy_b), packs RATIO consecutive WIDTH-bit beats into one wide
//  word, and presents the word on a registered valid/ready output (data_c/vld_c/rdy_c).
//  A flush request emits a partially filled word, with a lane mask (keep_c).
// PARAMETERS
//  WIDTH  32  bits per input beat
//  RATIO  4   beats per output word; legal range 2..16
// PORTS
//  clk      in   1            single clock; all state updates on posedge
//  rst_n    in   1            asynchronous, active-low reset
//  data_b   in   WIDTH        input beat
//  vld_b    in   1            input valid
//  rdy_b    out  1            input ready (combinational from state and rdy_c)
//  flush    in   1            level request: emit the partial word
//  data_c   out  WIDTH*RATIO  packed word; lane k = bits [k*WIDTH +: WIDTH]
//  keep_c   out  RATIO        lane-valid mask; bit k set = lane k holds data
//  vld_c    out  1            output valid (registered)
//  rdy_c    in   1            output ready from the consumer
// BEHAVIOUR
//  Reset (async on rst_n low): idx=0; acc=0; data_c=0; keep_c=0; vld_c=0; state=ACC;
//   rdy_b=1 once rst_n is high.
//  Handshakes: in_fire = vld_b & rdy_b; out_fire = vld_c & rdy_c.
//   slot_free = !vld_c | rdy_c.
//  Stability: once vld_c=1, data_c, keep_c and vld_c hold until out_fire.
//   vld_b is never required to depend on rdy_b.
//  Lane order: the first accepted beat goes to lane 0 (LSBs); idx counts 0..RATIO-1.
//  State ACC:
//   - rdy_b = (idx != RATIO-1) | slot_free.
//   - in_fire and idx < RATIO-1: acc[idx] <= data_b; idx++.
//   - in_fire and idx == RATIO-1: data_c <= {data_b, acc[RATIO-2:0]};
//     keep_c <= all ones; vld_c <= 1; idx <= 0 (wrap).
//   - Latency: vld_c rises in the cycle after the last beat is accepted.
//     Sustained throughput is 1 beat/clk when rdy_c = 1.
//   - flush=1 with in_fire: the beat is included first (lane idx).
//     The flush then covers idx+1 lanes; handle it as below.
//   - flush=1, lanes held > 0, slot_free: emit in the same clock edge.
//     data_c = held lanes, unused lanes zero; keep_c = low (lanes) bits set;
//     vld_c <= 1; idx <= 0.
//   - flush=1, lanes held > 0, slot not free: go to FLUSH_WAIT.
//   - flush=1, lanes held == 0: no-op; a full word that completes on this beat is
//     emitted normally.
//  State FLUSH_WAIT:
//   - rdy_b = 0.
//   - On slot_free: emit the partial word as above; return to ACC.
//   - flush deasserting here does not cancel the pending flush.
//  Output: out_fire with no new word loaded -> vld_c <= 0 and keep_c <= 0.
//   Word load with out_fire in the same cycle -> back-to-back words, no bubble.
//  Width rules: idx is $clog2(RATIO) bits. keep_c is a thermometer code, never zero
//   while vld_c = 1.
//  Reset mid-word: partial data is discarded, with no output beat; idx = 0 after reset.
// STRUCTURE
//  stream_pkg:
//   - typedef enum logic {ACC, FLUSH_WAIT} pack_state_e
//   - function thermo(n): n low bits set
//   - default WIDTH localparam, shared with the bubble stage
//  One sub-module: pack_out_slot. It is the output register: load, out_fire, hold.
//   stream_pack instantiates it once.
// TESTING
//  1. rdy_c=1; beats 0x11,0x22,0x33,0x44 on consecutive clks
//     -> next clk data_c=0x00000044_00000033_00000022_00000011, keep_c=4'b1111,
//        vld_c=1 for 1 clk.
//  2. rdy_c=0 after word 1 held; feed 3 more beats then a 4th
//     -> rdy_b=0 on the 4th until rdy_c=1, then word 2 loads in that cycle;
//        no beat lost or duplicated.
//  3. Beats 0xA,0xB then flush=1 for 1 clk, slot free
//     -> data_c lanes0/1 = 0xA/0xB, lanes2/3 = 0, keep_c=4'b0011, idx=0.
//  4. Flush while vld_c=1 and rdy_c=0
//     -> FLUSH_WAIT, rdy_b=0; on rdy_c=1 the held word leaves and the partial word
//        follows on the next clk.
//  5. flush=1 with idx=0 and no beat -> no output. flush together with the 4th beat
//     -> one full word, keep_c=4'b1111.
//  6. rst_n low mid-word (idx=2) -> vld_c=0, keep_c=0 immediately, no output.
//     After release, 4 beats give one correct word.
//  All runs: a scoreboard against a reference queue model, random vld_b and rdy_c,
//   1000 clks; assert vld_c holds stable until out_fire.

Source files
------------

// File: rtl/stream_pkg.sv
// Shared types and helpers for the stream blocks.
//  - pack_state_e : control state of the packer (accumulate / waiting to flush)
//  - thermo()     : thermometer mask with the n low bits set
//  - DEF_WIDTH    : default beat width, shared with the bubble-free stage
package stream_pkg;

    localparam int DEF_WIDTH = 32;
    // Widest lane mask thermo() can produce; callers cast down to their RATIO.
    localparam int MAX_RATIO = 16;

    typedef enum logic {ACC, FLUSH_WAIT} pack_state_e;

    function automatic logic [MAX_RATIO-1:0] thermo(input int n);
        logic [MAX_RATIO-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_RATIO; i++) begin
            if (i < n) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/pack_out_slot.sv
// Output register of the packer: holds one packed word with its lane mask.
//  clk, rst_n   clock, asynchronous active-low reset
//  load         capture load_data/load_keep (only asserted when the slot is free)
//  load_data    packed word to present
//  load_keep    lane mask of that word
//  rdy_c        consumer ready
//  data_c       presented word (stable while vld_c=1 until accepted)
//  keep_c       presented lane mask (zero whenever the slot is empty)
//  vld_c        presented valid
module pack_out_slot #(
    parameter int WIDTH = 32,
    parameter int RATIO = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic [WIDTH*RATIO-1:0] load_data,
    input  logic [RATIO-1:0]       load_keep,
    input  logic                   rdy_c,
    output logic [WIDTH*RATIO-1:0] data_c,
    output logic [RATIO-1:0]       keep_c,
    output logic                   vld_c
);

    logic [WIDTH*RATIO-1:0] data_q, data_d;
    logic [RATIO-1:0]       keep_q, keep_d;
    logic                   vld_q, vld_d;

    always_comb begin
        data_d = data_q;
        keep_d = keep_q;
        vld_d  = vld_q;
        // A load wins over a departing word so back-to-back words have no bubble.
        if (load) begin
            data_d = load_data;
            keep_d = load_keep;
            vld_d  = 1'b1;
        end else if (vld_q && rdy_c) begin
            keep_d = '0;
            vld_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            keep_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            keep_q <= keep_d;
            vld_q  <= vld_d;
        end
    end

    assign data_c = data_q;
    assign keep_c = keep_q;
    assign vld_c  = vld_q;

endmodule

// File: rtl/stream_pack.sv
// Packs RATIO consecutive WIDTH-bit beats into one wide word; a flush request
// emits a partially filled word with a thermometer lane mask.
//  clk, rst_n      clock, asynchronous active-low reset
//  data_b/vld_b    input beat stream
//  rdy_b           input ready (combinational from state and rdy_c)
//  flush           level request to emit the partial word
//  data_c/keep_c   packed word and lane mask; lane k = data_c[k*WIDTH +: WIDTH]
//  vld_c/rdy_c     registered output handshake
module stream_pack
    import stream_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int RATIO = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WIDTH-1:0]       data_b,
    input  logic                   vld_b,
    output logic                   rdy_b,
    input  logic                   flush,
    output logic [WIDTH*RATIO-1:0] data_c,
    output logic [RATIO-1:0]       keep_c,
    output logic                   vld_c,
    input  logic                   rdy_c
);

    localparam int IDX_W = $clog2(RATIO);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

    pack_state_e                  state_q, state_d;
    logic [IDX_W-1:0]             idx_q, idx_d;
    logic [RATIO-1:0][WIDTH-1:0]  acc_q, acc_d;

    logic                         slot_free;
    logic                         in_fire;
    logic [RATIO-1:0][WIDTH-1:0]  merged;      // held lanes plus this cycle's beat
    logic [CNT_W-1:0]             lanes_held;  // lanes covered, including this beat
    logic                         load;
    logic [CNT_W-1:0]             load_lanes;
    logic [RATIO-1:0]             load_keep;
    logic [WIDTH*RATIO-1:0]       load_data;

    assign slot_free = !vld_c || rdy_c;
    // Only the completing beat needs the output slot; earlier beats just fill acc.
    assign rdy_b     = (state_q == ACC) && ((idx_q != LAST_IDX) || slot_free);
    assign in_fire   = vld_b && rdy_b;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        acc_d      = acc_q;
        load       = 1'b0;
        load_lanes = '0;
        merged     = acc_q;
        if (in_fire) begin
            merged[idx_q] = data_b;
        end
        lanes_held = {1'b0, idx_q} + CNT_W'(in_fire);

        case (state_q)
            ACC: begin
                if (in_fire && (idx_q == LAST_IDX)) begin
                    // Full word; a simultaneous flush has nothing left over.
                    load       = 1'b1;
                    load_lanes = CNT_W'(RATIO);
                    idx_d      = '0;
                end else if (flush && (lanes_held != '0)) begin
                    if (slot_free) begin
                        load       = 1'b1;
                        load_lanes = lanes_held;
                        idx_d      = '0;
                    end else begin
                        // Never a full word here, so lanes_held fits in idx.
                        state_d = FLUSH_WAIT;
                        acc_d   = merged;
                        idx_d   = lanes_held[IDX_W-1:0];
                    end
                end else if (in_fire) begin
                    acc_d = merged;
                    idx_d = idx_q + 1'b1;
                end
            end
            FLUSH_WAIT: begin
                // The pending flush is latched; flush dropping does not cancel it.
                if (slot_free) begin
                    load       = 1'b1;
                    load_lanes = {1'b0, idx_q};
                    idx_d      = '0;
                    state_d    = ACC;
                end
            end
            default: state_d = ACC;
        endcase
    end

    assign load_keep = RATIO'(thermo(int'(load_lanes)));

    // Stale lanes from earlier words stay in acc; the mask zeroes them on load.
    generate
        for (genvar gi = 0; gi < RATIO; gi++) begin : g_lane
            assign load_data[gi*WIDTH +: WIDTH] = load_keep[gi] ? merged[gi] : '0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACC;
            idx_q   <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
        end
    end

    pack_out_slot #(
        .WIDTH(WIDTH),
        .RATIO(RATIO)
    ) u_out_slot (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_data(load_data),
        .load_keep(load_keep),
        .rdy_c    (rdy_c),
        .data_c   (data_c),
        .keep_c   (keep_c),
        .vld_c    (vld_c)
    );

endmodule

// File: tb/tb_stream_pack.sv
module tb_stream_pack;

    logic         clk;
    logic         rst_n;
    logic [31:0]  data_b;
    logic         vld_b;
    logic         rdy_b;
    logic         flush;
    logic [127:0] data_c;
    logic [3:0]   keep_c;
    logic         vld_c;
    logic         rdy_c;

    typedef struct {
        logic [127:0] data;
        logic [3:0]   keep;
    } word_t;

    word_t        sb[$];
    logic [31:0]  beats[$];
    int           n_checks;
    int           n_errors;
    int           n_words;
    logic         hold_prev;
    logic [127:0] prev_data;
    logic [3:0]   prev_keep;

    stream_pack #(
        .WIDTH(32),
        .RATIO(4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .data_b(data_b),
        .vld_b (vld_b),
        .rdy_b (rdy_b),
        .flush (flush),
        .data_c(data_c),
        .keep_c(keep_c),
        .vld_c (vld_c),
        .rdy_c (rdy_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: at the negedge compare outputs and update the reference model
    // with the handshakes that the coming posedge will perform.
    task automatic tick();
        word_t w;
        @(negedge clk);
        if (hold_prev) begin
            chk("hold_vld", 128'(vld_c), 128'(1'b1));
            chk("hold_data", data_c, prev_data);
            chk("hold_keep", 128'(keep_c), 128'(prev_keep));
        end
        if (vld_c && rdy_c) begin
            if (sb.size() == 0) begin
                chk("unexpected_word", 128'(vld_c), 128'(1'b0));
            end else begin
                w = sb.pop_front();
                chk("word_data", data_c, w.data);
                chk("word_keep", 128'(keep_c), 128'(w.keep));
                n_words++;
                $display("word %0d data=%h keep=%b", n_words, data_c, keep_c);
            end
        end
        if (vld_b && rdy_b) beats.push_back(data_b);
        if (beats.size() == 4 || (flush && beats.size() > 0)) begin
            w.data = '0;
            foreach (beats[k]) w.data[k*32 +: 32] = beats[k];
            w.keep = 4'((1 << beats.size()) - 1);
            sb.push_back(w);
            beats.delete();
        end
        hold_prev = vld_c && !rdy_c;
        prev_data = data_c;
        prev_keep = keep_c;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d);
        vld_b  = 1'b1;
        data_b = d;
        tick();
        vld_b  = 1'b0;
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        n_words   = 0;
        hold_prev = 1'b0;
        prev_data = '0;
        prev_keep = '0;
        rst_n  = 1'b0;
        vld_b  = 1'b0;
        data_b = '0;
        flush  = 1'b0;
        rdy_c  = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_vld", 128'(vld_c), 128'(1'b0));
        chk("rst_keep", 128'(keep_c), 128'(4'b0000));
        chk("rst_data", data_c, 128'(0));
        rst_n = 1'b1;
        #1;
        chk("rst_rdy_b", 128'(rdy_b), 128'(1'b1));

        // 1: four beats, one full word for one clock
        send(32'h11); send(32'h22); send(32'h33); send(32'h44);
        chk("t1_vld", 128'(vld_c), 128'(1'b1));
        chk("t1_data", data_c, 128'h00000044_00000033_00000022_00000011);
        chk("t1_keep", 128'(keep_c), 128'(4'b1111));
        tick();
        chk("t1_vld_drop", 128'(vld_c), 128'(1'b0));

        // 2: backpressure on the completing beat
        rdy_c = 1'b0;
        send(32'h101); send(32'h102); send(32'h103); send(32'h104);
        send(32'h201); send(32'h202); send(32'h203);
        vld_b  = 1'b1;
        data_b = 32'h204;
        #1;
        chk("t2_rdy_b_low", 128'(rdy_b), 128'(1'b0));
        tick(); tick();
        chk("t2_rdy_b_still_low", 128'(rdy_b), 128'(1'b0));
        rdy_c = 1'b1;
        #1;
        chk("t2_rdy_b_high", 128'(rdy_b), 128'(1'b1));
        tick();
        vld_b = 1'b0;
        chk("t2_word2", data_c, 128'h00000204_00000203_00000202_00000201);
        chk("t2_vld", 128'(vld_c), 128'(1'b1));
        tick();

        // 3: flush with two lanes, slot free
        send(32'hA); send(32'hB);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t3_data", data_c, 128'h00000000_00000000_0000000B_0000000A);
        chk("t3_keep", 128'(keep_c), 128'(4'b0011));
        tick();

        // 4: flush while the slot is occupied
        rdy_c = 1'b0;
        send(32'h301); send(32'h302); send(32'h303); send(32'h304);
        send(32'h401); send(32'h402);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t4_rdy_b_wait", 128'(rdy_b), 128'(1'b0));
        tick();
        chk("t4_rdy_b_wait2", 128'(rdy_b), 128'(1'b0));
        chk("t4_held", data_c, 128'h00000304_00000303_00000302_00000301);
        rdy_c = 1'b1;
        tick();
        chk("t4_partial", data_c, 128'h00000000_00000000_00000402_00000401);
        chk("t4_keep", 128'(keep_c), 128'(4'b0011));
        chk("t4_vld", 128'(vld_c), 128'(1'b1));
        tick();
        chk("t4_rdy_b_back", 128'(rdy_b), 128'(1'b1));

        // 5: empty flush, then flush with the completing beat
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t5_no_output", 128'(vld_c), 128'(1'b0));
        send(32'h501); send(32'h502); send(32'h503);
        flush = 1'b1;
        send(32'h504);
        flush = 1'b0;
        chk("t5_keep", 128'(keep_c), 128'(4'b1111));
        chk("t5_data", data_c, 128'h00000504_00000503_00000502_00000501);
        tick();

        // 6: reset mid-word with a word held
        rdy_c = 1'b0;
        send(32'h601); send(32'h602); send(32'h603); send(32'h604);
        send(32'h605); send(32'h606);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_vld", 128'(vld_c), 128'(1'b0));
        chk("t6_keep", 128'(keep_c), 128'(4'b0000));
        chk("t6_data", data_c, 128'(0));
        sb.delete();
        beats.delete();
        hold_prev = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rdy_c = 1'b1;
        send(32'h701); send(32'h702); send(32'h703); send(32'h704);
        chk("t6_word", data_c, 128'h00000704_00000703_00000702_00000701);
        tick();

        // Random traffic against the reference model
        for (int i = 0; i < 1000; i++) begin
            vld_b  = 1'($urandom_range(0, 1));
            data_b = $urandom;
            flush  = ($urandom_range(0, 15) == 0);
            rdy_c  = 1'($urandom_range(0, 1));
            tick();
        end
        vld_b = 1'b0;
        flush = 1'b0;
        rdy_c = 1'b1;
        repeat (8) tick();
        chk("drain_empty", 128'(sb.size()), 128'(0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
